program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
32-bit program counter register for the single-cycle datapath. It loads the next-instruction address from upstream logic (PC+4 adder or branch/jump mux) on every rising clock edge. It presents the current instruction address to instruction memory and the PC+4 adder. Synchronous reset forces the PC to the reset vector.

Parameters:
ADDR_WIDTH, 32, width of Address and PCResult in bits.
RESET_VALUE, 32'h00000000, value loaded into PCResult on reset.

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset; sampled only on the rising edge of Clk.
Address  input  ADDR_WIDTH  next PC value to be loaded.
PCResult  output  ADDR_WIDTH  current PC value, registered.

Behaviour:
- Single register, PCResult, driven directly from a flop with no combinational path from Address or Reset.
- On each rising edge of Clk:
  - If Reset=1: PCResult <= RESET_VALUE. Address is ignored.
  - Else: PCResult <= Address.
- Reset is synchronous. Asserting or deasserting Reset between edges has no effect until the next rising edge.
- Reset has priority over load. When Reset=1 and Address changes in the same cycle, the result is RESET_VALUE.
- Latency is one cycle. A value on Address at edge N appears on PCResult right after edge N and holds until edge N+1.
- No enable or stall: the PC loads every cycle. Holding Address constant holds PCResult constant.
- Full-width transfer with no arithmetic, masking or alignment. Values such as 32'hFFFFFFFF and unaligned addresses pass through unchanged.
- Before the first rising edge with Reset=1, PCResult is undefined (X in simulation). The system must apply Reset for at least one edge.
- Reset mid-operation: the next edge forces RESET_VALUE regardless of prior PC. Normal loading resumes on the first edge with Reset=0.

Test Plan:
- Reset from power-up: Clk period 10 ns with first rising edge at 5 ns; Reset=1, Address=32'h4 at t=0 -> PCResult=32'h0 after edge at 5 ns.
- Release and load: Reset=0 at 10 ns, Address=32'h4 -> PCResult=32'h4 after edge at 15 ns.
- Sequential loads: Address=32'h8 at 20 ns -> PCResult=32'h8 after 25 ns. Address=32'hC at 30 ns -> PCResult=32'hC after 35 ns. PCResult still 32'hC after 45 ns with Address unchanged.
- Synchronous check: toggle Address and Reset between edges (e.g. Reset pulse from 41 to 44 ns) -> PCResult does not change until the next rising edge, and that pulse produces no reset.
- Reset mid-run: PCResult=32'h0000_1234, then Reset=1 for one edge with Address=32'h0000_5678 -> PCResult=32'h0. Release Reset -> PCResult=32'h0000_5678 after the next edge.
- Width extremes: Address=32'hFFFF_FFFF then 32'h0000_0003 -> PCResult follows exactly, one cycle later, with no masking.

Source files
------------

// File: rtl/program_counter.sv
// Program counter register for the single-cycle datapath: loads the next
// instruction address every rising edge, or the reset vector when Reset is high.
module program_counter #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] Address,
    output logic [ADDR_WIDTH-1:0] PCResult
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;

    // Reset wins over the load; Address passes through untouched otherwise.
    always_comb begin
        pc_d = Address;
        if (Reset) begin
            pc_d = RESET_VALUE;
        end
    end

    always_ff @(posedge Clk) begin
        pc_q <= pc_d;
    end

    assign PCResult = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed table, hand-written
// between-edge sequences and randomized loads against a simple reference.
module tb_program_counter;

    localparam int          W  = 32;
    localparam logic [31:0] RV = 32'h0000_0000;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [W-1:0]  Address;
    logic [W-1:0]  PCResult;

    int n_cmp = 0;
    int n_bad = 0;

    program_counter #(.ADDR_WIDTH(W), .RESET_VALUE(RV)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Address  (Address),
        .PCResult (PCResult)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: PCResult=%h required=%h @%0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: PCResult=%h @%0t", name, act, $time);
        end
    endtask

    // Inputs are driven just after a falling edge and the result is sampled
    // on the following falling edge, i.e. half a cycle after the loading edge.
    task automatic step(input string name, input logic r, input logic [31:0] a, input logic [31:0] exp);
        Reset   = r;
        Address = a;
        @(negedge Clk);
        check(name, PCResult, exp);
    endtask

    vec_t        tbl [5];
    logic [31:0] ref_pc;
    logic [31:0] held;
    logic        r;
    logic [31:0] a;

    initial begin
        tbl[0] = '{1'b1, 32'h0000_0004, 32'h0000_0000};
        tbl[1] = '{1'b0, 32'h0000_0004, 32'h0000_0004};
        tbl[2] = '{1'b0, 32'h0000_0008, 32'h0000_0008};
        tbl[3] = '{1'b0, 32'h0000_000C, 32'h0000_000C};
        tbl[4] = '{1'b0, 32'h0000_000C, 32'h0000_000C};

        // Table applied from t=0: first check at 10 ns after the 5 ns edge.
        for (int i = 0; i < 5; i++) begin
            step($sformatf("table[%0d]", i), tbl[i].rst, tbl[i].addr, tbl[i].exp);
        end

        // Short Reset pulse and Address change strictly between edges.
        held = PCResult;
        #1 Reset = 1'b1; Address = 32'h0000_0020;
        #2 Address = 32'h0000_0024;
        #1 Reset = 1'b0;
        check("between_edges_hold", PCResult, held);
        @(negedge Clk);
        check("pulse_no_reset", PCResult, 32'h0000_0024);

        // Output must not move before the edge that loads it.
        Address = 32'h0000_0100;
        @(posedge Clk);
        #1;
        check("one_cycle_latency", PCResult, 32'h0000_0100);
        Address = 32'h0000_0200;
        @(posedge Clk);
        #1;
        check("one_cycle_latency2", PCResult, 32'h0000_0200);
        @(negedge Clk);

        // Reset in the middle of operation, then release.
        step("mid_load",     1'b0, 32'h0000_1234, 32'h0000_1234);
        step("mid_reset",    1'b1, 32'h0000_5678, RV);
        step("mid_release",  1'b0, 32'h0000_5678, 32'h0000_5678);

        // Width extremes and unaligned values.
        step("all_ones",     1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step("unaligned",    1'b0, 32'h0000_0003, 32'h0000_0003);
        step("alt_bits",     1'b0, 32'hAAAA_5555, 32'hAAAA_5555);
        step("reset_ones",   1'b1, 32'hFFFF_FFFF, RV);

        // Randomized loads: the PC equals whatever was presented at the last
        // edge, or the reset vector if Reset was high there.
        for (int i = 0; i < 200; i++) begin
            r = ($urandom_range(0, 7) == 0);
            a = $urandom();
            ref_pc = r ? RV : a;
            step($sformatf("rand[%0d] rst=%0b addr=%h", i, r, a), r, a, ref_pc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
